class_hvec_stream: RTL and testbench

CLASS_HVEC_STREAM -- requirements
Module: class_hvec_stream

---
 rtl/class_hvec_stream_pkg.sv | 18 +
 rtl/class_hvec_mem.sv | 47 ++++
 rtl/class_hvec_stream.sv | 154 +++++++++++++++
 tb/tb_class_hvec_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/class_hvec_stream_pkg.sv
// rtl/class_hvec_stream_pkg.sv - shared defaults, FSM state enum and width helper for class_hvec_stream
package class_hvec_stream_pkg;

    localparam int FRAME_W_DEF   = 64;
    localparam int N_CLASSES_DEF = 8;
    localparam int N_FRAMES_DEF  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Index width that never collapses to zero for single-entry dimensions
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/class_hvec_mem.sv
// rtl/class_hvec_mem.sv - 1R/1W synchronous frame store, read-before-write, contents never reset
module class_hvec_mem
    import class_hvec_stream_pkg::*;
#(
    parameter int DATA_W = FRAME_W_DEF,
    parameter int DEPTH  = N_CLASSES_DEF * N_FRAMES_DEF,
    parameter int ADDR_W = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The array update lands on the same edge, so a colliding read sees the old word
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/class_hvec_stream.sv
// rtl/class_hvec_stream.sv - streams the stored frames of a requested class vector, one frame per cycle
module class_hvec_stream
    import class_hvec_stream_pkg::*;
#(
    parameter int FRAME_W   = FRAME_W_DEF,
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int N_FRAMES  = N_FRAMES_DEF,
    parameter int CLS_W     = clog2_min1(N_CLASSES),
    parameter int FRM_W     = clog2_min1(N_FRAMES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CLS_W-1:0]   req_class,
    input  logic               wr_en,
    input  logic [CLS_W-1:0]   wr_class,
    input  logic [FRM_W-1:0]   wr_frame,
    input  logic [FRAME_W-1:0] wr_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_data,
    output logic [CLS_W-1:0]   out_class,
    output logic [FRM_W-1:0]   out_frame,
    output logic               out_last,
    output logic               err_class
);

    localparam int DEPTH  = N_CLASSES * N_FRAMES;
    localparam int ADDR_W = clog2_min1(DEPTH);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [CLS_W-1:0]   out_class_q, out_class_d;
    logic [FRM_W-1:0]   out_frame_q, out_frame_d;
    logic               out_last_q, out_last_d;
    logic               err_q, err_d;

    logic               accept;
    logic               req_ok;
    logic [FRM_W-1:0]   next_frame;
    logic               rd_en;
    logic [CLS_W-1:0]   rd_class;
    logic [FRM_W-1:0]   rd_frame;
    logic [ADDR_W-1:0]  rd_addr;
    logic               wr_ok;
    logic [ADDR_W-1:0]  wr_addr;

    assign accept     = req_valid && (state_q == IDLE);
    assign req_ok     = 32'(req_class) < N_CLASSES;
    assign next_frame = out_frame_q + FRM_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && req_ok) state_d = STREAM;
            STREAM:  if (out_ready && out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each handshake fetches the following frame, so a write lands in the stream until that fetch
    always_comb begin
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_frame_d = out_frame_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        rd_en       = 1'b0;
        rd_class    = out_class_q;
        rd_frame    = next_frame;
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (accept) begin
                    if (req_ok) begin
                        rd_en       = 1'b1;
                        rd_class    = req_class;
                        rd_frame    = '0;
                        out_valid_d = 1'b1;
                        out_class_d = req_class;
                        out_frame_d = '0;
                        out_last_d  = (N_FRAMES == 1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                    end else begin
                        rd_en       = 1'b1;
                        out_frame_d = next_frame;
                        out_last_d  = (32'(next_frame) == N_FRAMES - 1);
                    end
                end
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_frame_q <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_frame_q <= out_frame_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign rd_addr = ADDR_W'(32'(rd_class) * 32'(N_FRAMES) + 32'(rd_frame));
    assign wr_ok   = wr_en && (32'(wr_class) < N_CLASSES) && (32'(wr_frame) < N_FRAMES);
    assign wr_addr = ADDR_W'(32'(wr_class) * 32'(N_FRAMES) + 32'(wr_frame));

    class_hvec_mem #(
        .DATA_W (FRAME_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (out_data)
    );

    assign req_ready = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_frame = out_frame_q;
    assign out_last  = out_last_q;
    assign err_class = err_q;

endmodule

// File: tb/tb_class_hvec_stream.sv
// tb/tb_class_hvec_stream.sv - randomized self-checking bench for class_hvec_stream against a frame-array model
module tb_class_hvec_stream;

    localparam int FW  = 64;
    localparam int NC  = 6;
    localparam int NF  = 3;
    localparam int CW  = 3;
    localparam int FMW = 2;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_class;
    logic          wr_en;
    logic [CW-1:0] wr_class;
    logic [FMW-1:0] wr_frame;
    logic [FW-1:0] wr_data;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_data;
    logic [CW-1:0] out_class;
    logic [FMW-1:0] out_frame;
    logic          out_last;
    logic          err_class;

    logic [FW-1:0] mem_m [NC][NF];
    int pass_cnt  = 0;
    int total_cnt = 0;

    class_hvec_stream #(
        .FRAME_W   (FW),
        .N_CLASSES (NC),
        .N_FRAMES  (NF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_class (req_class),
        .wr_en     (wr_en),
        .wr_class  (wr_class),
        .wr_frame  (wr_frame),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_class (out_class),
        .out_frame (out_frame),
        .out_last  (out_last),
        .err_class (err_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model rule: out-of-range writes leave storage untouched
    task automatic do_write(input int c, input int f, input logic [FW-1:0] d);
        wr_en = 1'b1; wr_class = CW'(c); wr_frame = FMW'(f); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (c < NC && f < NF) mem_m[c][f] = d;
    endtask

    task automatic stream_class(input int cls, input int stall_f, input int stall_n,
                                input bit rnd, input string tag);
        int f = 0;
        int waited = 0;
        int cyc = 0;
        bit stall;
        logic [1+CW+FMW+1+FW-1:0] exp_v, got_v;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL %s req_ready_idle got %b exp 1", tag, req_ready);
        else pass_cnt++;
        req_valid = 1'b1; req_class = CW'(cls); out_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (f < NF && cyc < 60) begin
            stall = rnd && ($urandom_range(0, 2) == 0);
            if (f == stall_f && waited < stall_n) begin
                stall = 1'b1;
                waited++;
            end
            out_ready = !stall;
            exp_v = {1'b1, CW'(cls), FMW'(f), (f == NF - 1), mem_m[cls][f]};
            got_v = {out_valid, out_class, out_frame, out_last, out_data};
            total_cnt++;
            if (got_v !== exp_v || req_ready !== 1'b0)
                $display("FAIL %s frame%0d got %h rdy %b exp %h rdy 0", tag, f, got_v, req_ready, exp_v);
            else pass_cnt++;
            @(posedge clk); #1;
            cyc++;
            if (!stall) f++;
        end
        total_cnt++;
        if (f != NF) $display("FAIL %s timeout frames %0d exp %0d", tag, f, NF);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL %s end valid %b ready %b exp 0 1", tag, out_valid, req_ready);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_class = '0; wr_en = 1'b0;
        wr_class = '0; wr_frame = '0; wr_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, err_class, out_last, out_data, out_class, out_frame} !== '0)
            $display("FAIL reset_outputs got %b %b %b %h exp all 0", out_valid, err_class, out_last, out_data);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++)
                do_write(c, f, {$urandom, $urandom});
    endtask

    task automatic test_basic();
        do_write(2, 0, {16{4'h1}});
        do_write(2, 1, {16{4'h2}});
        do_write(2, 2, {16{4'h3}});
        stream_class(2, -1, 0, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        stream_class(2, 1, 4, 1'b0, "backpressure");
    endtask

    task automatic test_err(input int c);
        req_valid = 1'b1; req_class = CW'(c);
        @(posedge clk); #1;
        req_valid = 1'b0;
        total_cnt++;
        if ({err_class, out_valid, req_ready} !== 3'b101)
            $display("FAIL err_pulse cls%0d got err %b val %b rdy %b exp 1 0 1", c, err_class, out_valid, req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({err_class, out_valid, req_ready} !== 3'b001)
            $display("FAIL err_after cls%0d got err %b val %b rdy %b exp 0 0 1", c, err_class, out_valid, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_write_during_stream();
        logic [FW-1:0] old1;
        logic [FW-1:0] new1;
        old1 = mem_m[5][1];
        new1 = {$urandom, $urandom};
        req_valid = 1'b1; req_class = 3'd5; out_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wr_en = 1'b1; wr_class = 3'd5; wr_frame = 2'd2; wr_data = {16{4'hA, 4'hB, 4'hC, 4'hD}} ;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== mem_m[5][0])
            $display("FAIL wds_frame0 got %b %h exp 1 %h", out_valid, out_data, mem_m[5][0]);
        else pass_cnt++;
        @(posedge clk); #1;
        mem_m[5][2] = {16{4'hA, 4'hB, 4'hC, 4'hD}};
        out_ready = 1'b1;
        wr_frame = 2'd1; wr_data = new1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mem_m[5][1] = new1;
        total_cnt++;
        if (out_frame !== 2'd1 || out_data !== old1)
            $display("FAIL wds_collide got f%0d %h exp f1 %h", out_frame, out_data, old1);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_frame !== 2'd2 || out_data !== mem_m[5][2])
            $display("FAIL wds_frame2 got f%0d %h exp f2 %h", out_frame, out_data, mem_m[5][2]);
        else pass_cnt++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        stream_class(5, -1, 0, 1'b0, "wds_reread");
    endtask

    task automatic test_reset_mid_stream();
        req_valid = 1'b1; req_class = 3'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_frame !== 2'd1)
            $display("FAIL rstmid_pre got %b f%0d exp 1 f1", out_valid, out_frame);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== '0 || req_ready !== 1'b1)
            $display("FAIL rstmid_abort got %b %h %b exp 0 0 1", out_valid, out_data, req_ready);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_quiet got %b exp 0", out_valid);
        else pass_cnt++;
        stream_class(3, -1, 0, 1'b0, "rstmid_reread");
    endtask

    task automatic test_bad_write();
        for (int c = 0; c < NC; c++) do_write(c, 3, {$urandom, $urandom});
        do_write(6, 0, {$urandom, $urandom});
        do_write(7, 2, {$urandom, $urandom});
        for (int c = 0; c < NC; c++) stream_class(c, -1, 0, 1'b0, "badwrite");
    endtask

    task automatic test_random();
        int c;
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 3))
                do_write($urandom_range(0, 7), $urandom_range(0, 3), {$urandom, $urandom});
            c = $urandom_range(0, 7);
            if (c >= NC) test_err(c);
            else stream_class(c, $urandom_range(0, NF - 1), $urandom_range(0, 3), 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_backpressure();
        test_err(7);
        test_err(6);
        test_write_during_stream();
        test_reset_mid_stream();
        test_bad_write();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
